// File: rtl/fraud_result_collector.sv
// fraud_result_collector: show-ahead decision FIFO with saturating stats; define FRAUD_IRQ_EN for the fraud interrupt
module fraud_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_data_valid,
  input  logic                       i_clear,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_data_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_fifo_count,
  output logic [CNT_WIDTH-1:0]       o_total_cnt,
  output logic [CNT_WIDTH-1:0]       o_fraud_cnt,
  output logic                       o_overflow,
  output logic                       o_irq,
  input  logic                       i_irq_ack
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, pop, push, fraud;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop = !empty && i_ready;
  assign push = i_data_valid && (!full || pop);
  assign fraud = |i_data;
  assign o_data_valid = !empty;
  assign o_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign o_fifo_count = wr_ptr - rd_ptr;
  // storage write; when full with a pop the freed head slot is the write slot
  always_ff @(posedge i_clk)
    if (push && !i_clear) mem[wr_ptr[AW-1:0]] <= i_data;
  // pointers, saturating statistics and sticky overflow; clear beats everything
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_total_cnt <= '0;
      o_fraud_cnt <= '0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_total_cnt <= '0;
      o_fraud_cnt <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (i_data_valid && !push) o_overflow <= 1'b1;
      if (i_data_valid && o_total_cnt != '1) o_total_cnt <= o_total_cnt + CNT_ONE;
      if (i_data_valid && fraud && o_fraud_cnt != '1) o_fraud_cnt <= o_fraud_cnt + CNT_ONE;
    end
`ifdef FRAUD_IRQ_EN
  // fraud interrupt: any nonzero strobe (kept or dropped) sets, ack clears, set wins
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_irq <= 1'b0;
    else if (i_data_valid && fraud && !i_clear) o_irq <= 1'b1;
    else if (i_irq_ack) o_irq <= 1'b0;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = i_irq_ack;
  assign o_irq = 1'b0;
`endif
endmodule

// File: tb/tb_fraud_result_collector.sv
// tb_fraud_result_collector: scoreboard bench for fraud_result_collector (IRQ checks follow FRAUD_IRQ_EN)
module tb_fraud_result_collector;
  localparam int DEPTH = 16;
  logic i_clk = 0, i_rst_n = 0, i_data_valid = 0, i_clear = 0, i_ready = 0, i_irq_ack = 0;
  logic [31:0] i_data = 0, o_data, o_total_cnt, o_fraud_cnt;
  logic o_data_valid, o_overflow, o_irq;
  logic [4:0] o_fifo_count;
  int checks = 0, fails = 0;
  logic [31:0] q[$];
  int mtot = 0, mfraud = 0;
  logic movf = 0, mirq = 0;

  fraud_result_collector #(.DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_data_valid(i_data_valid),
    .i_clear(i_clear), .o_data(o_data), .o_data_valid(o_data_valid), .i_ready(i_ready),
    .o_fifo_count(o_fifo_count), .o_total_cnt(o_total_cnt), .o_fraud_cnt(o_fraud_cnt),
    .o_overflow(o_overflow), .o_irq(o_irq), .i_irq_ack(i_irq_ack));

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_count"}, 64'(o_fifo_count), 64'(q.size()));
    check({tag, "_total"}, 64'(o_total_cnt), 64'(mtot));
    check({tag, "_fraud"}, 64'(o_fraud_cnt), 64'(mfraud));
    check({tag, "_ovf"}, 64'(o_overflow), 64'(movf));
    check({tag, "_irq"}, 64'(o_irq), 64'(mirq));
  endtask

  task automatic model_zero();
    q.delete();
    mtot = 0;
    mfraud = 0;
    movf = 0;
  endtask

  // called at a negedge: drives one cycle, scoreboards any pop, returns at next negedge
  task automatic cycle(input logic v, input logic [31:0] d, input logic rdy);
    logic p;
    logic [31:0] e;
    i_data_valid = v;
    i_data = d;
    i_ready = rdy;
    p = rdy && q.size() != 0;
    check("valid", 64'(o_data_valid), 64'(q.size() != 0));
    if (p) begin
      e = q.pop_front();
      check("pop_data", 64'(o_data), 64'(e));
    end
    if (v) begin
      mtot++;
      if (d != 0) mfraud++;
      if (q.size() < DEPTH) q.push_back(d);
      else movf = 1;
    end
`ifdef FRAUD_IRQ_EN
    if (v && d != 0) mirq = 1;
    else if (i_irq_ack) mirq = 0;
`endif
    @(negedge i_clk);
    i_data_valid = 0;
    i_ready = 0;
    i_irq_ack = 0;
  endtask

  task automatic clear_cycle(input logic v, input logic [31:0] d, input logic rdy);
    i_clear = 1;
    i_data_valid = v;
    i_data = d;
    i_ready = rdy;
    @(negedge i_clk);
    i_clear = 0;
    i_data_valid = 0;
    i_ready = 0;
    model_zero();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() != 0; k++) cycle(0, 0, 1);
    check("drained_valid", 64'(o_data_valid), 64'(0));
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    check("rst_data", 64'(o_data), 64'(0));
    check("rst_valid", 64'(o_data_valid), 64'(0));
    check_stats("rst");
    i_rst_n = 1;
    @(negedge i_clk);
    // single push then pop
    cycle(1, 1, 0);
    check("single_data", 64'(o_data), 64'(1));
    check_stats("single");
    cycle(0, 0, 1);
    check("single_popped", 64'(o_data_valid), 64'(0));
    // overflow with alternating 0/1
    clear_cycle(0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 32'(i % 2), 0);
    check_stats("ovf");
    check("ovf_count16", 64'(o_fifo_count), 64'(16));
    drain();
    check_stats("ovf_drained");
    // full plus simultaneous push/pop
    clear_cycle(0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'(32'h10 + i), 0);
    cycle(1, 32'hAA, 1);
    check_stats("full_pp");
    check("full_pp_count16", 64'(o_fifo_count), 64'(16));
    check("full_pp_last", 64'(q[q.size()-1]), 64'(32'hAA));
    drain();
    // streaming across wrap
    for (int i = 0; i < 40; i++) begin
      cycle(1, $urandom, 1);
      check("stream_le1", 64'(o_fifo_count <= 1), 64'(1));
    end
    cycle(0, 0, 1);
    check_stats("stream");
    // clear with simultaneous push at count 5
    for (int i = 0; i < 5; i++) cycle(1, 32'(i + 3), 0);
    check("pre_clear_count", 64'(o_fifo_count), 64'(5));
    clear_cycle(1, 32'h7, 0);
    check("clr_valid", 64'(o_data_valid), 64'(0));
    check_stats("clr");
    // async reset mid-drain
    for (int i = 0; i < 6; i++) cycle(1, 32'(i + 9), 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    i_ready = 1;
    #2 i_rst_n = 0;
    #1;
    model_zero();
    mirq = 0;
    check("arst_data", 64'(o_data), 64'(0));
    check("arst_valid", 64'(o_data_valid), 64'(0));
    check_stats("arst");
    #1 i_rst_n = 1;
    i_ready = 0;
    @(negedge i_clk);
    // interrupt behaviour
    cycle(1, 0, 0);
    check_stats("irq_zero");
    cycle(1, 5, 0);
    check_stats("irq_fraud");
    i_irq_ack = 1;
    cycle(1, 6, 0);
    check_stats("irq_set_wins");
    i_irq_ack = 1;
    cycle(0, 0, 0);
    check_stats("irq_ack");
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
